pcie_lane_gate: RTL and testbench

Parametrised successor to the fixed 8-lane PCIe lane bury/pass-through.
- Carries LANES differential rx/tx lane pairs through an optional register pipeline.
- Lanes are grouped into GROUPS equal lane groups. Each group has its own enable-sequencing FSM (settle on enable, drain on disable).
- While a group is not active, its lanes are forced to an idle pattern.
- Sits between the PCIe hard-IP lane pins and the BlueNoC PCIe wrapper.

---
 rtl/pcie_lane_pkg.sv | 24 ++
 rtl/pcie_lane_group_fsm.sv | 87 ++++++++
 rtl/pcie_lane_gate.sv | 123 ++++++++++++
 tb/tb_pcie_lane_gate.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_lane_pkg.sv
// +----------------------------------------------------------------------------+
// | pcie_lane_pkg                                                              |
// | Shared lane-group state encoding and idle-pattern constants.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pcie_lane_pkg;

    typedef enum logic [1:0] {
        LANE_OFF    = 2'd0,
        LANE_SETTLE = 2'd1,
        LANE_ON     = 2'd2,
        LANE_DRAIN  = 2'd3
    } lane_state_e;

    localparam logic IDLE_P = 1'b0;
    localparam logic IDLE_N = 1'b1;

    localparam int CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/pcie_lane_group_fsm.sv
// +----------------------------------------------------------------------------+
// | pcie_lane_group_fsm                                                        |
// | Enable sequencer for one lane group: settle on enable, drain on disable.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pcie_lane_group_fsm #(
    parameter int SETTLE_CYCLES = 16,
    parameter int PIPE          = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_pass,
    output logic o_busy
);
    import pcie_lane_pkg::*;

    localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_drain  = CNT_W'(PIPE);

    lane_state_e        r_state;
    lane_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LANE_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LANE_OFF: begin
                if (i_en) begin
                    w_state_nxt = LANE_SETTLE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            LANE_SETTLE: begin
                // Dropping enable mid-settle discards all accumulated credit.
                if (!i_en) begin
                    w_state_nxt = LANE_OFF;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_settle) begin
                    w_state_nxt = LANE_ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            LANE_ON: begin
                if (!i_en) begin
                    w_state_nxt = LANE_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            LANE_DRAIN: begin
                // Enable is deliberately ignored until the pipeline has flushed.
                if (r_cnt == c_drain) begin
                    w_state_nxt = LANE_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = LANE_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_pass = (r_state == LANE_ON) || (r_state == LANE_DRAIN);
    assign o_busy = (r_state == LANE_SETTLE) || (r_state == LANE_DRAIN);

endmodule

`default_nettype wire

// File: rtl/pcie_lane_gate.sv
// +----------------------------------------------------------------------------+
// | pcie_lane_gate                                                             |
// | Grouped PCIe lane gate: pipelined pass-through, idle forcing per group.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pcie_lane_gate #(
    parameter int LANES         = 8,
    parameter int GROUPS        = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int PIPE          = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [LANES-1:0]             rxp_in,
    input  logic [LANES-1:0]             rxn_in,
    input  logic [LANES-1:0]             txp_in,
    input  logic [LANES-1:0]             txn_in,
    input  logic [GROUPS-1:0]            en,
    output logic [LANES-1:0]             rxp_out,
    output logic [LANES-1:0]             rxn_out,
    output logic [LANES-1:0]             txp_out,
    output logic [LANES-1:0]             txn_out,
    output logic [GROUPS-1:0]            group_active,
    output logic [$clog2(LANES+1)-1:0]   active_lanes,
    output logic                         busy
);
    import pcie_lane_pkg::*;

    localparam int GL = LANES / GROUPS;
    localparam int AW = $clog2(LANES + 1);
    localparam int BW = 4 * LANES;

    localparam logic [AW-1:0] c_gl   = AW'(GL);
    localparam logic [BW-1:0] c_idle = {{LANES{IDLE_N}}, {LANES{IDLE_P}},
                                        {LANES{IDLE_N}}, {LANES{IDLE_P}}};

    if (((LANES % GROUPS) != 0) || (PIPE < 0) || (PIPE > 3)) begin : g_bad_params
        $error("pcie_lane_gate: LANES must divide by GROUPS and PIPE must be 0..3");
    end

    logic [BW-1:0]      w_bus_in;
    logic [BW-1:0]      w_pipe_out;
    logic [BW-1:0]      w_mask;
    logic [BW-1:0]      w_bus_out;
    logic [LANES-1:0]   w_lane_pass;
    logic [GROUPS-1:0]  w_busy;
    logic [AW-1:0]      w_active_sum;
    logic [AW-1:0]      r_active_lanes;

    // All four buses share one pipeline so they stay cycle-aligned.
    assign w_bus_in = {txn_in, txp_in, rxn_in, rxp_in};

    if (PIPE == 0) begin : g_pipe_none
        assign w_pipe_out = w_bus_in;
    end else begin : g_pipe
        logic [BW-1:0] r_pipe [PIPE];

        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int s = 0; s < PIPE; s++) begin
                    r_pipe[s] <= c_idle;
                end
            end else begin
                r_pipe[0] <= w_bus_in;
                for (int s = 1; s < PIPE; s++) begin
                    r_pipe[s] <= r_pipe[s-1];
                end
            end
        end

        assign w_pipe_out = r_pipe[PIPE-1];
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        pcie_lane_group_fsm #(
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .PIPE          (PIPE)
        ) u_fsm (
            .clk    (CLK),
            .rst    (RST),
            .i_en   (en[g]),
            .o_pass (group_active[g]),
            .o_busy (w_busy[g])
        );
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_pass[l] = group_active[l / GL];
    end

    assign w_mask    = {4{w_lane_pass}};
    assign w_bus_out = (w_pipe_out & w_mask) | (c_idle & ~w_mask);

    assign rxp_out = w_bus_out[0*LANES +: LANES];
    assign rxn_out = w_bus_out[1*LANES +: LANES];
    assign txp_out = w_bus_out[2*LANES +: LANES];
    assign txn_out = w_bus_out[3*LANES +: LANES];

    always_comb begin
        w_active_sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (group_active[g]) begin
                w_active_sum = w_active_sum + c_gl;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_active_lanes <= '0;
        end else begin
            r_active_lanes <= w_active_sum;
        end
    end

    assign active_lanes = r_active_lanes;
    assign busy         = |w_busy;

endmodule

`default_nettype wire

// File: tb/tb_pcie_lane_gate.sv
// +----------------------------------------------------------------------------+
// | tb_pcie_lane_gate                                                          |
// | Directed vector bench for pcie_lane_gate in three parameterisations.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pcie_lane_gate;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // Instance A: defaults (8 lanes, 4 groups, settle 16, pipe 1)
    logic [3:0] r_en_a;
    logic [7:0] r_rxp_a, r_rxn_a, r_txp_a, r_txn_a;
    logic [7:0] w_rxp_a, w_rxn_a, w_txp_a, w_txn_a;
    logic [3:0] w_ga_a;
    logic [3:0] w_al_a;
    logic       w_busy_a;

    pcie_lane_gate u_dut_a (
        .CLK(CLK), .RST(RST),
        .rxp_in(r_rxp_a), .rxn_in(r_rxn_a), .txp_in(r_txp_a), .txn_in(r_txn_a),
        .en(r_en_a),
        .rxp_out(w_rxp_a), .rxn_out(w_rxn_a), .txp_out(w_txp_a), .txn_out(w_txn_a),
        .group_active(w_ga_a), .active_lanes(w_al_a), .busy(w_busy_a)
    );

    // Instance B: two pipeline stages
    logic [3:0] r_en_b;
    logic [7:0] r_rxp_b, r_rxn_b, r_txp_b, r_txn_b;
    logic [7:0] w_rxp_b, w_rxn_b, w_txp_b, w_txn_b;
    logic [3:0] w_ga_b;
    logic [3:0] w_al_b;
    logic       w_busy_b;

    pcie_lane_gate #(.LANES(8), .GROUPS(4), .SETTLE_CYCLES(16), .PIPE(2)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .rxp_in(r_rxp_b), .rxn_in(r_rxn_b), .txp_in(r_txp_b), .txn_in(r_txn_b),
        .en(r_en_b),
        .rxp_out(w_rxp_b), .rxn_out(w_rxn_b), .txp_out(w_txp_b), .txn_out(w_txn_b),
        .group_active(w_ga_b), .active_lanes(w_al_b), .busy(w_busy_b)
    );

    // Instance C: 16 lanes in 2 groups
    logic [1:0]  r_en_c;
    logic [15:0] r_rxp_c, r_rxn_c, r_txp_c, r_txn_c;
    logic [15:0] w_rxp_c, w_rxn_c, w_txp_c, w_txn_c;
    logic [1:0]  w_ga_c;
    logic [4:0]  w_al_c;
    logic        w_busy_c;

    pcie_lane_gate #(.LANES(16), .GROUPS(2), .SETTLE_CYCLES(16), .PIPE(1)) u_dut_c (
        .CLK(CLK), .RST(RST),
        .rxp_in(r_rxp_c), .rxn_in(r_rxn_c), .txp_in(r_txp_c), .txn_in(r_txn_c),
        .en(r_en_c),
        .rxp_out(w_rxp_c), .rxn_out(w_rxn_c), .txp_out(w_txp_c), .txn_out(w_txn_c),
        .group_active(w_ga_c), .active_lanes(w_al_c), .busy(w_busy_c)
    );

    typedef struct {
        logic [3:0] en;
        logic [7:0] rxp;
        int         ncyc;
        logic [7:0] e_rxp, e_rxn, e_txp, e_txn;
        logic [3:0] e_ga;
        logic [3:0] e_al;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic [3:0] en, logic [7:0] rxp, int ncyc,
                                logic [7:0] e_rxp, logic [7:0] e_rxn,
                                logic [7:0] e_txp, logic [7:0] e_txn,
                                logic [3:0] e_ga, logic [3:0] e_al, logic e_busy);
        vec_t v;
        v.en = en; v.rxp = rxp; v.ncyc = ncyc;
        v.e_rxp = e_rxp; v.e_rxn = e_rxn; v.e_txp = e_txp; v.e_txn = e_txn;
        v.e_ga = e_ga; v.e_al = e_al; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // n == 0 only lets combinational inputs settle, without a clock edge.
    task automatic step(input int n);
        if (n == 0) begin
            #1;
        end else begin
            repeat (n) @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        // Lane data on A: rxp A5, rxn 5A, txp 3C, txn C3; group g owns lanes [2g+1:2g].
        tbl.push_back(mk(4'h0, 8'hA5,  2, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 4'd0, 1'b0));
        tbl.push_back(mk(4'h1, 8'hA5,  1, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 4'd0, 1'b1));
        tbl.push_back(mk(4'h1, 8'hA5, 14, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 4'd0, 1'b1));
        tbl.push_back(mk(4'h1, 8'hA5,  1, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 4'd0, 1'b1));
        tbl.push_back(mk(4'h1, 8'hA5,  1, 8'h01, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd0, 1'b0));
        tbl.push_back(mk(4'h1, 8'hA5,  1, 8'h01, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd2, 1'b0));
        tbl.push_back(mk(4'h1, 8'h02,  0, 8'h01, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd2, 1'b0));
        tbl.push_back(mk(4'h1, 8'h02,  1, 8'h02, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd2, 1'b0));
        tbl.push_back(mk(4'h5, 8'h02, 10, 8'h02, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd2, 1'b1));
        tbl.push_back(mk(4'h1, 8'h02,  1, 8'h02, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd2, 1'b0));
        tbl.push_back(mk(4'h5, 8'h02, 16, 8'h02, 8'hFE, 8'h00, 8'hFF, 4'h1, 4'd2, 1'b1));
        tbl.push_back(mk(4'h5, 8'h02,  1, 8'h02, 8'hDE, 8'h30, 8'hCF, 4'h5, 4'd2, 1'b0));
        tbl.push_back(mk(4'h5, 8'h02,  1, 8'h02, 8'hDE, 8'h30, 8'hCF, 4'h5, 4'd4, 1'b0));
        tbl.push_back(mk(4'h4, 8'h02,  1, 8'h02, 8'hDE, 8'h30, 8'hCF, 4'h5, 4'd4, 1'b1));
        tbl.push_back(mk(4'h4, 8'h02,  1, 8'h02, 8'hDE, 8'h30, 8'hCF, 4'h5, 4'd4, 1'b1));
        tbl.push_back(mk(4'h4, 8'h02,  1, 8'h00, 8'hDF, 8'h30, 8'hCF, 4'h4, 4'd4, 1'b0));
        tbl.push_back(mk(4'h4, 8'h02,  1, 8'h00, 8'hDF, 8'h30, 8'hCF, 4'h4, 4'd2, 1'b0));

        r_en_b = '0; r_rxp_b = 8'h01; r_rxn_b = 8'hFF; r_txp_b = 8'h00; r_txn_b = 8'hFF;
        r_en_c = '0; r_rxp_c = 16'hA5A5; r_rxn_c = 16'h5A5A; r_txp_c = 16'h3C3C; r_txn_c = 16'hC3C3;

        // Reset held with random lane traffic and enables
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r_en_a  = 4'($urandom);
            r_rxp_a = 8'($urandom); r_rxn_a = 8'($urandom);
            r_txp_a = 8'($urandom); r_txn_a = 8'($urandom);
            step(1);
            chk($sformatf("reset_a%0d", i),
                {w_rxp_a, w_rxn_a, w_txp_a, w_txn_a, w_ga_a, w_al_a, w_busy_a},
                {8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 4'd0, 1'b0});
        end
        chk("reset_c", {w_rxp_c, w_rxn_c, w_txp_c, w_txn_c, w_ga_c, w_al_c, w_busy_c},
            {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 2'b00, 5'd0, 1'b0});

        RST = 1'b0;
        r_rxn_a = 8'h5A; r_txp_a = 8'h3C; r_txn_a = 8'hC3;
        foreach (tbl[i]) begin
            r_en_a  = tbl[i].en;
            r_rxp_a = tbl[i].rxp;
            step(tbl[i].ncyc);
            chk($sformatf("vec%0d", i),
                {w_rxp_a, w_rxn_a, w_txp_a, w_txn_a, w_ga_a, w_al_a, w_busy_a},
                {tbl[i].e_rxp, tbl[i].e_rxn, tbl[i].e_txp, tbl[i].e_txn,
                 tbl[i].e_ga, tbl[i].e_al, tbl[i].e_busy});
        end

        // B: PIPE=2 latency, 3-cycle drain, enable ignored during drain
        r_en_b = 4'h1;
        step(16);
        chk("b_settle", {w_ga_b, w_busy_b, w_rxp_b}, {4'h0, 1'b1, 8'h00});
        step(1);
        chk("b_on", {w_ga_b, w_busy_b, w_rxp_b}, {4'h1, 1'b0, 8'h01});
        r_rxp_b = 8'h02;
        step(1);
        chk("b_lat1", w_rxp_b, 8'h01);
        step(1);
        chk("b_lat2", w_rxp_b, 8'h02);
        r_en_b = 4'h0;
        step(1);
        chk("b_drain0", {w_ga_b, w_busy_b, w_rxp_b}, {4'h1, 1'b1, 8'h02});
        r_en_b = 4'h1;
        step(1);
        chk("b_drain1", {w_ga_b, w_busy_b, w_rxp_b}, {4'h1, 1'b1, 8'h02});
        step(1);
        chk("b_drain2", {w_ga_b, w_busy_b, w_rxp_b}, {4'h1, 1'b1, 8'h02});
        step(1);
        chk("b_off", {w_ga_b, w_busy_b, w_rxp_b}, {4'h0, 1'b0, 8'h00});
        step(16);
        chk("b_resettle", {w_ga_b, w_busy_b}, {4'h0, 1'b1});
        step(1);
        chk("b_reon", {w_ga_b, w_busy_b, w_rxp_b}, {4'h1, 1'b0, 8'h02});

        // C: both groups of a 16-lane gate enabled together
        r_en_c = 2'b11;
        step(16);
        chk("c_settle", {w_ga_c, w_busy_c, w_rxp_c}, {2'b00, 1'b1, 16'h0000});
        step(1);
        chk("c_on", {w_rxp_c, w_rxn_c, w_txp_c, w_txn_c, w_ga_c, w_al_c, w_busy_c},
            {16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hC3C3, 2'b11, 5'd0, 1'b0});
        step(1);
        chk("c_lanes", w_al_c, 5'd16);

        // A: reset while group 2 is ON and groups 0/1 are settling
        r_en_a = 4'h7;
        step(3);
        chk("a_pre_rst", {w_ga_a, w_busy_a}, {4'h4, 1'b1});
        RST = 1'b1;
        step(1);
        chk("a_mid_rst", {w_rxp_a, w_rxn_a, w_txp_a, w_txn_a, w_ga_a, w_al_a, w_busy_a},
            {8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 4'd0, 1'b0});
        chk("c_mid_rst", {w_rxp_c, w_ga_c, w_al_c, w_busy_c}, {16'h0000, 2'b00, 5'd0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
